// File: rtl/fetch_unit.sv
// fetch_unit: multicycle-datapath front end owning PC, IR and MDR.
// Converts the controller's single-cycle read intent into a req/ack memory
// transaction, freezes the controller via stall while a read is in flight,
// and returns the opcode of the instruction register.
// Optional build macro: FETCH_ALIGN_CHECK_EN -- misaligned fetches are turned
// into a nop load with a sticky addr_err flag instead of a memory request.
module fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              branch_en,
  input  logic              alu_zero,
  input  logic [1:0]        pc_src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              ior_d,
  input  logic              ir_write,
  input  logic              md_read,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q;
  logic              mem_req_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_d;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] mdr_q;
  logic              dest_ir_q;

  logic              req;
  logic              pc_en;
  logic              misalign_fetch;
  logic [DATA_W-1:0] sel_addr;
  logic [DATA_W-1:0] aligned_addr;
  logic [DATA_W-1:0] jump_target;

  // Any read intent from the controller; ir_write takes priority for the
  // destination choice when both are raised together.
  assign req = ir_write | md_read;

  // Address source: PC for instruction fetch, alu_out for loads (or for
  // fetches steered through ior_d). Memory is word addressed, so the two
  // low bits are cleared here and only here; the PC itself keeps them.
  assign sel_addr     = ior_d ? alu_out : pc_q;
  assign aligned_addr = sel_addr & {{(DATA_W-2){1'b1}}, 2'b00};

  // The controller must not advance while a request is being accepted or is
  // in flight. HOLD deliberately releases the stall so the controller can
  // move on while requests are still presented (they are ignored there).
  assign stall = ((state_q == ST_IDLE) & req) | (state_q == ST_WAIT);

  // PC writes are suppressed while stalled so the fetch address cannot move
  // underneath an outstanding request; the update lands in HOLD instead.
  assign pc_en = (pc_write | (branch_en & alu_zero)) & ~stall;

  assign jump_target = {pc_q[DATA_W-1:DATA_W-4], instr_q[25:0], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  // Only genuine PC-based fetches are checked; data reads keep dropping
  // their low address bits.
  assign misalign_fetch = ir_write & ~ior_d & (pc_q[1:0] != 2'b00);
`else
  assign misalign_fetch = 1'b0;
`endif

  // Next-PC selection; pc_src = 11 holds the current value.
  always_comb begin
    pc_d = pc_q;
    case (pc_src)
      2'b00:   pc_d = alu_result;
      2'b01:   pc_d = alu_out;
      2'b10:   pc_d = jump_target;
      default: pc_d = pc_q;
    endcase
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (pc_en) begin
      pc_q <= pc_d;
    end
  end

  // Transaction FSM with registered request, address and load destinations.
  // A reset in WAIT simply returns to IDLE with mem_req low, so any ack
  // that arrives afterwards is outside WAIT and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      instr_q    <= '0;
      mdr_q      <= '0;
      dest_ir_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            dest_ir_q <= ir_write;
            if (misalign_fetch) begin
              // Replace the bad fetch with a nop and skip the memory.
              instr_q <= '0;
              state_q <= ST_HOLD;
            end else begin
              mem_addr_q <= aligned_addr;
              mem_req_q  <= 1'b1;
              state_q    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            if (dest_ir_q) begin
              instr_q <= mem_rdata;
            end else begin
              mdr_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            state_q   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Controller still shows the same state this cycle; ignore it.
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic addr_err_q;

  // Sticky misaligned-fetch flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err_q <= 1'b0;
    end else if ((state_q == ST_IDLE) & req & misalign_fetch) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
`else
  assign addr_err = 1'b0;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign opcode   = instr_q[DATA_W-1:DATA_W-6];
  assign mdr      = mdr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// transaction-level reference model (expected PC/IR/MDR per access).
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, branch_en, alu_zero, ior_d, ir_write, md_read, mem_ack;
  logic [1:0]  pc_src;
  logic [31:0] alu_result, alu_out, mem_rdata;
  logic        mem_req, stall, addr_err;
  logic [31:0] mem_addr, pc, instr, mdr;
  logic [5:0]  opcode;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_mdr;

  fetch_unit #(.DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .branch_en(branch_en),
    .alu_zero(alu_zero), .pc_src(pc_src), .alu_result(alu_result),
    .alu_out(alu_out), .ior_d(ior_d), .ir_write(ir_write), .md_read(md_read),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_addr(mem_addr), .pc(pc), .instr(instr), .opcode(opcode), .mdr(mdr),
    .stall(stall), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Next PC from the controller's intent, in plain arithmetic.
  function automatic logic [31:0] model_pc(input logic [31:0] cur_pc, input logic [31:0] cur_ir,
                                           input logic pcw, input logic be, input logic az,
                                           input logic [1:0] src, input logic [31:0] ar,
                                           input logic [31:0] ao);
    if (!(pcw || (be && az))) return cur_pc;
    case (src)
      2'd0:    return ar;
      2'd1:    return ao;
      2'd2:    return (cur_pc & 32'hF000_0000) + (cur_ir % 32'h0400_0000) * 4;
      default: return cur_pc;
    endcase
  endfunction

  task automatic idle_inputs();
    pc_write = 0; branch_en = 0; alu_zero = 0; pc_src = 2'b11;
    alu_result = 0; alu_out = 0; ior_d = 0; ir_write = 0; md_read = 0;
    mem_rdata = 0; mem_ack = 0;
  endtask

  // One complete memory access; entered and left #1 after a rising edge in IDLE.
  // wc = number of WAIT cycles, ack arrives in the last one.
  task automatic access(input string nm, input logic ir, input logic md, input logic iord,
                        input logic pcw, input logic be, input logic az, input logic [1:0] src,
                        input logic [31:0] ar, input logic [31:0] ao,
                        input logic [31:0] rdata, input int wc);
    logic [31:0] exp_addr;
    int scount;
    scount = 0;
    exp_addr = ((iord ? ao : m_pc) / 4) * 4;
    ir_write = ir; md_read = md; ior_d = iord; pc_write = pcw; branch_en = be;
    alu_zero = az; pc_src = src; alu_result = ar; alu_out = ao;
    #1;
    if (stall === 1'b1) scount++;
    chk({nm, "_req_idle"}, mem_req, 0);
    @(posedge clk); #1;
    for (int w = 0; w < wc; w++) begin
      chk({nm, "_req_wait"}, mem_req, 1);
      chk({nm, "_addr"}, mem_addr, exp_addr);
      chk({nm, "_pc_frozen"}, pc, m_pc);
      mem_ack = (w == wc - 1);
      mem_rdata = (w == wc - 1) ? rdata : $urandom;
      #1;
      if (stall === 1'b1) scount++;
      @(posedge clk); #1;
      mem_ack = 0;
    end
    // HOLD cycle: data loaded, stall released, requests still presented
    if (ir) m_instr = rdata; else m_mdr = rdata;
    #1;
    if (stall === 1'b1) scount++;
    chk({nm, "_stall_cycles"}, scount, wc + 1);
    chk({nm, "_req_hold"}, mem_req, 0);
    chk({nm, "_instr"}, instr, m_instr);
    chk({nm, "_opcode"}, opcode, m_instr / 32'h0400_0000);
    chk({nm, "_mdr"}, mdr, m_mdr);
    m_pc = model_pc(m_pc, m_instr, pcw, be, az, src, ar, ao);
    @(posedge clk); #1;
    chk({nm, "_pc_after"}, pc, m_pc);
    chk({nm, "_req_after"}, mem_req, 0);
    idle_inputs();
  endtask

  // PC update with no memory request; a stray ack is also offered.
  task automatic pc_step(input string nm, input logic pcw, input logic be, input logic az,
                         input logic [1:0] src, input logic [31:0] ar, input logic [31:0] ao);
    pc_write = pcw; branch_en = be; alu_zero = az; pc_src = src;
    alu_result = ar; alu_out = ao; mem_ack = 1; mem_rdata = $urandom;
    #1;
    chk({nm, "_stall"}, stall, 0);
    m_pc = model_pc(m_pc, m_instr, pcw, be, az, src, ar, ao);
    @(posedge clk); #1;
    chk({nm, "_pc"}, pc, m_pc);
    chk({nm, "_instr_kept"}, instr, m_instr);
    chk({nm, "_req"}, mem_req, 0);
    idle_inputs();
  endtask

  initial begin
    logic        is_f, iord_r;
    logic [1:0]  src_r;
    logic [31:0] ao_r;

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_pc = RST_PC; m_instr = 0; m_mdr = 0;
    chk("rst_pc", pc, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_mdr", mdr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_addr_err", addr_err, 0);

    // Basic fetch with immediate ack
    access("fetch1", 1, 0, 0, 1, 0, 0, 2'b00, 32'h0040_0004, 0, 32'h2008_0005, 1);
    chk("fetch1_opcode_val", opcode, 6'h08);
    chk("fetch1_pc_val", pc, 32'h0040_0004);

    // Delayed ack: 4 WAIT cycles, 5 stall cycles
    access("fetch_slow", 1, 0, 0, 1, 0, 0, 2'b00, 32'h0040_0008, 0, $urandom, 4);

    // Conditional branch not taken, then taken
    pc_step("br_nt", 0, 1, 0, 2'b01, 0, 32'h0040_0020);
    pc_step("br_t", 0, 1, 1, 2'b01, 0, 32'h0040_0020);
    chk("br_t_val", pc, 32'h0040_0020);

    // Jump: pc=0x00400008, instr=0x08100004
    pc_step("set_pc", 1, 0, 0, 2'b00, 32'h0040_0008, 0);
    access("jump", 1, 0, 0, 1, 0, 0, 2'b10, 0, 0, 32'h0810_0004, 1);
    chk("jump_val", pc, 32'h0040_0010);

    // Data read through alu_out with misaligned address
    access("load", 0, 1, 1, 0, 0, 0, 2'b11, 0, 32'h1001_0003, 32'hDEAD_BEEF, 2);
    chk("load_mdr_val", mdr, 32'hDEAD_BEEF);
    chk("load_instr_kept", instr, 32'h0810_0004);

    // Both requests at once: instruction register wins
    access("both", 1, 1, 0, 0, 0, 0, 2'b11, 0, 0, 32'hA5A5_0001, 1);

    // Randomized accesses
    for (int k = 0; k < 16; k++) begin
      is_f   = 1'($urandom % 2);
      iord_r = 1'($urandom % 2);
      src_r  = 2'($urandom % 4);
      ao_r   = is_f ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      if (!is_f && src_r == 2'b01) src_r = 2'b00;
      access("rand", is_f, ~is_f | 1'($urandom % 2), iord_r, 1'($urandom % 2),
             1'($urandom % 2), 1'($urandom % 2), src_r, $urandom & 32'hFFFF_FFFC,
             ao_r, $urandom, 1 + int'($urandom % 4));
    end

    // Reset in WAIT, then a late ack
    ir_write = 1;
    #1;
    chk("rstw_stall", stall, 1);
    @(posedge clk); #1;
    chk("rstw_req_wait", mem_req, 1);
    rst = 1; ir_write = 0;
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
    m_pc = RST_PC; m_instr = 0; m_mdr = 0;
    #1;
    chk("rstw_req", mem_req, 0);
    chk("rstw_pc", pc, RST_PC);
    chk("rstw_instr", instr, 0);
    chk("rstw_stall0", stall, 0);
    @(posedge clk); #1;
    mem_ack = 0;
    chk("rstw_late_instr", instr, 0);
    chk("rstw_late_mdr", mdr, 0);
    chk("rstw_late_req", mem_req, 0);

    // Misaligned fetch
    access("pre_mis", 1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 32'hCAFE_F00D, 1);
    pc_step("mis_pc", 1, 0, 0, 2'b00, 32'h0040_0002, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    ir_write = 1;
    #1;
    chk("mis_stall_idle", stall, 1);
    @(posedge clk); #1;
    chk("mis_no_req", mem_req, 0);
    chk("mis_stall_hold", stall, 0);
    chk("mis_instr_nop", instr, 0);
    chk("mis_addr_err", addr_err, 1);
    ir_write = 0;
    @(posedge clk); #1;
    chk("mis_err_sticky", addr_err, 1);
    chk("mis_req_after", mem_req, 0);
`else
    access("mis", 1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 32'h0BAD_0001, 1);
    chk("mis_addr_dropped", mem_addr, 32'h0040_0000);
    chk("mis_addr_err", addr_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
